// File: rtl/hazard_scoreboard.sv
// ============================================================================
// hazard_scoreboard
//   Hazard unit for the 5-stage pipeline: load-use / branch-load stalls,
//   EX and D-stage forwarding, and a per-register scoreboard that tracks
//   pending writes from variable-latency (div/mul) operations.
//   Optional: HAZ_PERF_EN adds stall_cycles / stall_cause outputs.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int NREG         = 32,
  parameter int AW           = $clog2(NREG),
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_D,
  input  logic [AW-1:0] rs2_D,
  input  logic [AW-1:0] rd_D,
  input  logic          issue_valid_D,
  input  logic          issue_long_D,
  input  logic          branch_D,
  input  logic          flush_D,
  input  logic [AW-1:0] rs1_E,
  input  logic [AW-1:0] rs2_E,
  input  logic [AW-1:0] rd_E,
  input  logic          use_rs2_E,
  input  logic [AW-1:0] rd_M,
  input  logic [AW-1:0] rd_W,
  input  logic          regwrite_E,
  input  logic          regwrite_M,
  input  logic          regwrite_W,
  input  logic          memtoreg_E,
  input  logic          memtoreg_M,
  input  logic          long_done,
  input  logic [AW-1:0] long_rd,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic [1:0]    BranchForwardAE,
  output logic [1:0]    BranchForwardBE,
  output logic [CW-1:0] inflight_cnt,
  output logic          sb_full,
  output logic          sb_err
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [2:0]    stall_cause
`endif
);

  localparam logic [CW-1:0] c_max_inflight = CW'(MAX_INFLIGHT);

  logic [NREG-1:0] r_pending;
  logic [CW-1:0]   r_inflight_cnt;
  logic            r_sb_err;

  logic [NREG-1:0] w_pending_nxt;
  logic            w_full;
  logic            w_load_use;
  logic            w_br_load;
  logic            w_raw;
  logic            w_waw;
  logic            w_struct;
  logic            w_stall;
  logic            w_issue;
  logic            w_complete;
  logic            w_bad_done;

  assign w_full = (r_inflight_cnt == c_max_inflight);

  // Every stall term looks only at registered scoreboard state, so a freed
  // register becomes usable one cycle after its completion edge.
  always_comb begin
    w_load_use = memtoreg_E & (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
    w_br_load  = branch_D & memtoreg_M & (rd_M != '0) &
                 ((rd_M == rs1_D) | (rd_M == rs2_D));
    w_raw      = issue_valid_D & (r_pending[rs1_D] | r_pending[rs2_D]);
    w_waw      = issue_valid_D & r_pending[rd_D];
    w_struct   = issue_valid_D & issue_long_D & w_full;
    w_stall    = w_load_use | w_br_load | w_raw | w_waw | w_struct;
  end

  assign w_issue    = issue_valid_D & issue_long_D & ~w_stall & ~flush_D & (rd_D != '0);
  assign w_complete = long_done & r_pending[long_rd] & (r_inflight_cnt != '0);
  assign w_bad_done = long_done & ~w_complete;

  generate
    for (genvar g = 0; g < NREG; g++) begin : g_pending
      if (g == 0) begin : g_zero
        assign w_pending_nxt[g] = 1'b0;
      end else begin : g_reg
        assign w_pending_nxt[g] = (r_pending[g] & ~(w_complete & (long_rd == AW'(g)))) |
                                  (w_issue & (rd_D == AW'(g)));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending      <= '0;
      r_inflight_cnt <= '0;
      r_sb_err       <= 1'b0;
    end else begin
      r_pending      <= w_pending_nxt;
      r_inflight_cnt <= r_inflight_cnt + CW'(w_issue) - CW'(w_complete);
      if (w_bad_done) begin
        r_sb_err <= 1'b1;
      end
    end
  end

  always_comb begin
    ForwardAE       = 2'b00;
    ForwardBE       = 2'b00;
    BranchForwardAE = 2'b00;
    BranchForwardBE = 2'b00;
    if (!rst) begin
      if (regwrite_M && (rd_M != '0) && (rd_M == rs1_E))      ForwardAE = 2'b10;
      else if (regwrite_W && (rd_W != '0) && (rd_W == rs1_E)) ForwardAE = 2'b01;

      if (use_rs2_E) begin
        if (regwrite_M && (rd_M != '0) && (rd_M == rs2_E))      ForwardBE = 2'b10;
        else if (regwrite_W && (rd_W != '0) && (rd_W == rs2_E)) ForwardBE = 2'b01;
      end

      if (regwrite_E && (rd_E != '0) && (rd_E == rs1_D))      BranchForwardAE = 2'b01;
      else if (regwrite_W && (rd_W != '0) && (rd_W == rs1_D)) BranchForwardAE = 2'b11;

      if (regwrite_E && (rd_E != '0) && (rd_E == rs2_D))      BranchForwardBE = 2'b01;
      else if (regwrite_W && (rd_W != '0) && (rd_W == rs2_D)) BranchForwardBE = 2'b11;
    end
  end

  assign StallF       = ~rst & w_stall;
  assign StallD       = ~rst & w_stall;
  assign FlushE       = ~rst & w_stall;
  assign inflight_cnt = r_inflight_cnt;
  assign sb_full      = ~rst & w_full;
  assign sb_err       = r_sb_err;

`ifdef HAZ_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [2:0]  r_stall_cause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_stall_cause  <= '0;
    end else if (w_stall) begin
      if (r_stall_cycles != 32'hFFFF_FFFF) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      r_stall_cause <= {w_struct, w_raw | w_waw, w_load_use | w_br_load};
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign stall_cause  = r_stall_cause;
`endif

endmodule

`default_nettype wire
